// File: rtl/yupferris_bitslam_pkg.sv
// Shared definitions for the bitslam pattern sequencer.
//   state_t      : sequencer FSM states
//   REG_*        : voice register addresses driven during address phases
//   ADDR_IDLE    : parked bus value, not a decoded voice register
//   step_t       : one step-table record at the default duration width
package yupferris_bitslam_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_A0,
    S_D0,
    S_A1,
    S_D1,
    S_HOLD
  } state_t;

  localparam logic [5:0] REG_CLK_DIV  = 6'h00;
  localparam logic [5:0] REG_TAP_MASK = 6'h01;
  localparam logic [5:0] ADDR_IDLE    = 6'h3F;

  localparam int DUR_W_DEF = 8;

  // Table words are packed in this field order: {div, taps, dur}.
  typedef struct packed {
    logic [5:0]           div;
    logic [3:0]           taps;
    logic [DUR_W_DEF-1:0] dur;
  } step_t;

endpackage

// File: rtl/yupferris_bitslam_seq_if.sv
// Multiplexed addr/data bus from the sequencer to the bitslam voice.
//   bus_sel  : 0 = address phase, 1 = data phase
//   bus_data : register address or register data
// master = sequencer side, slave = voice side.
interface yupferris_bitslam_seq_if;
  logic       bus_sel;
  logic [5:0] bus_data;

  modport master (output bus_sel, output bus_data);
  modport slave  (input  bus_sel, input  bus_data);
endinterface

// File: rtl/yupferris_bitslam_seq_table.sv
// Step table: STEPS x W register file.
//   clk            : write clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : combinational read port (returns pre-write data in the
//                    cycle of a write to the same entry)
module yupferris_bitslam_seq_table #(
  parameter  int STEPS = 8,
  parameter  int W     = 18,
  localparam int SW    = $clog2(STEPS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [SW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [SW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] r_mem [STEPS];

  // NOTE: storage arrays carry no reset; a reset would force a flop-per-bit
  // implementation and the host is expected to program entries before use.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/yupferris_bitslam_seq.sv
// Bitslam noise-voice pattern sequencer.
// Replays a programmable step table; each step writes the voice clock-divider
// and tap-mask registers (address then data) and then holds for
// (dur+1)*2^PRE_W cycles.
//   clk, rst                  : clock, synchronous active-high reset
//   prog_we/addr/div/taps/dur : step-table write port, usable at any time
//   run                       : 1 = play, 0 = stop after the current write pair
//   loop_last                 : last step index before wrapping to 0
//   vbus (master)             : addr/data bus to the voice
//   busy                      : high whenever not IDLE
//   step_idx                  : step currently being written or held
module yupferris_bitslam_seq
  import yupferris_bitslam_pkg::*;
#(
  parameter  int STEPS = 8,
  parameter  int DUR_W = 8,
  parameter  int PRE_W = 4,
  localparam int SW    = $clog2(STEPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prog_we,
  input  logic [SW-1:0]            prog_addr,
  input  logic [5:0]               prog_div,
  input  logic [3:0]               prog_taps,
  input  logic [DUR_W-1:0]         prog_dur,
  input  logic                     run,
  input  logic [SW-1:0]            loop_last,
  yupferris_bitslam_seq_if.master  vbus,
  output logic                     busy,
  output logic [SW-1:0]            step_idx
);

  localparam int TW = 10 + DUR_W;

  state_t           r_state;
  logic             r_bus_sel;
  logic [5:0]       r_bus_data;
  logic             r_busy;
  logic [SW-1:0]    r_idx;
  logic [PRE_W-1:0] r_pre;
  logic [DUR_W-1:0] r_hold;

  // Latched step; only meaningful after a load, so it carries no reset.
  logic [5:0]       r_div;
  logic [3:0]       r_taps;
  logic [DUR_W-1:0] r_dur;

  logic [SW-1:0]    w_next_idx;
  logic [SW-1:0]    w_rd_addr;
  logic [TW-1:0]    w_rd_data;
  logic             w_hold_done;
  logic             w_load;

  yupferris_bitslam_seq_table #(.STEPS(STEPS), .W(TW)) u_table (
    .clk   (clk),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata ({prog_div, prog_taps, prog_dur}),
    .raddr (w_rd_addr),
    .rdata (w_rd_data)
  );

  assign w_next_idx  = (r_idx == loop_last) ? '0 : r_idx + SW'(1);
  // IDLE always restarts at entry 0; otherwise the only load is at HOLD exit.
  assign w_rd_addr   = (r_state == S_IDLE) ? '0 : w_next_idx;
  // Exit test precedes the decrement, so the hold counter never underflows.
  assign w_hold_done = (r_pre == '1) && (r_hold == '0);
  assign w_load      = run && ((r_state == S_IDLE) ||
                               ((r_state == S_HOLD) && w_hold_done));

  always_ff @(posedge clk) begin
    if (w_load) begin
      r_div  <= w_rd_data[TW-1 -: 6];
      r_taps <= w_rd_data[DUR_W+3 -: 4];
      r_dur  <= w_rd_data[DUR_W-1:0];
    end
  end

  // Bus outputs are registered alongside the state so the voice sees one
  // clean value per cycle and sel=1 only in D0/D1.
  // NOTE: all state here uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bus_sel  <= 1'b0;
      r_bus_data <= ADDR_IDLE;
      r_busy     <= 1'b0;
      r_idx      <= '0;
      r_pre      <= '0;
      r_hold     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state    <= S_A0;
            r_idx      <= '0;
            r_bus_data <= REG_CLK_DIV;
            r_busy     <= 1'b1;
          end
        end
        S_A0: begin
          r_state    <= S_D0;
          r_bus_sel  <= 1'b1;
          r_bus_data <= r_div;
        end
        S_D0: begin
          r_state    <= S_A1;
          r_bus_sel  <= 1'b0;
          r_bus_data <= REG_TAP_MASK;
        end
        S_A1: begin
          r_state    <= S_D1;
          r_bus_sel  <= 1'b1;
          r_bus_data <= {2'b00, r_taps};
        end
        S_D1: begin
          r_bus_sel  <= 1'b0;
          r_bus_data <= ADDR_IDLE;
          if (run) begin
            r_state <= S_HOLD;
            r_pre   <= '0;
            r_hold  <= r_dur;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!run) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_pre <= r_pre + PRE_W'(1);
            if (r_pre == '1) begin
              if (r_hold == '0) begin
                r_state    <= S_A0;
                r_idx      <= w_next_idx;
                r_bus_data <= REG_CLK_DIV;
              end else begin
                r_hold <= r_hold - DUR_W'(1);
              end
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_bus_sel  <= 1'b0;
          r_bus_data <= ADDR_IDLE;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign vbus.bus_sel  = r_bus_sel;
  assign vbus.bus_data = r_bus_data;
  assign busy          = r_busy;
  assign step_idx      = r_idx;

endmodule
